// File: rtl/axi_crossbar_qos_arbiter_pkg.sv
// Shared helpers for the QoS arbiter: index width and the aged-port promotion level.
// Pure constants and functions; no timing, no flow control.
package axi_crossbar_qos_arbiter_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // An aged requester sits one level above the largest QoS value.
    function automatic logic [31:0] promo_level(input int unsigned qos_w);
        return 32'd1 << qos_w;
    endfunction

endpackage

// File: rtl/axi_crossbar_qos_arbiter_priority_encoder.sv
// Lowest-index-first priority encoder over a request vector.
// Combinational; no flow control.
module axi_crossbar_qos_arbiter_priority_encoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                vld_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi_crossbar_qos_arbiter.sv
// QoS arbiter with round-robin tie-break and aging promotion; registered one-hot/encoded grant.
// One-cycle latency request->grant; grant held per ARB_BLOCK/ARB_BLOCK_ACK (request level or ack pulse).
module axi_crossbar_qos_arbiter
    import axi_crossbar_qos_arbiter_pkg::*;
#(
    parameter int PORTS         = 4,
    parameter int QOS_WIDTH     = 4,
    parameter int AGE_WIDTH     = 8,
    parameter int AGE_LIMIT     = 64,
    parameter int ARB_BLOCK     = 1,
    parameter int ARB_BLOCK_ACK = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [PORTS-1:0]              request_i,
    input  logic [PORTS-1:0]              acknowledge_i,
    input  logic [PORTS*QOS_WIDTH-1:0]    req_qos_i,
    output logic [PORTS-1:0]              grant_o,
    output logic                          grant_valid_o,
    output logic [idx_width(PORTS)-1:0]   grant_encoded_o,
    output logic [QOS_WIDTH-1:0]          grant_qos_o,
    output logic [PORTS-1:0]              aged_o
);

    localparam int IDX_W  = idx_width(PORTS);
    localparam int PRIO_W = QOS_WIDTH + 1;
    localparam logic [PRIO_W-1:0]    PROMO   = PRIO_W'(promo_level(QOS_WIDTH));
    localparam logic [AGE_WIDTH-1:0] LIMIT_V = AGE_WIDTH'(AGE_LIMIT);

    logic [PORTS-1:0]                grant_q, grant_d;
    logic                            grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]                grant_enc_q, grant_enc_d;
    logic [QOS_WIDTH-1:0]            grant_qos_q, grant_qos_d;
    logic [IDX_W-1:0]                last_q, last_d;
    logic [PORTS-1:0][AGE_WIDTH-1:0] age_q, age_d;
    logic [PORTS-1:0]                aged_q, aged_d;

    logic [PORTS-1:0][PRIO_W-1:0]    prio;
    logic [PRIO_W-1:0]               max_prio;
    logic [PORTS-1:0]                cand, above;
    logic                            msk_vld, all_vld, held;
    logic [IDX_W-1:0]                msk_idx, all_idx, win_idx;

    // Candidates are the requesters at the highest effective level; "above" masks
    // indices past the last winner so the tie-break rotates.
    always_comb begin
        prio     = '0;
        max_prio = '0;
        cand     = '0;
        above    = '0;
        for (int i = 0; i < PORTS; i++) begin
            prio[i] = aged_q[i] ? PROMO : {1'b0, req_qos_i[i*QOS_WIDTH +: QOS_WIDTH]};
            if (request_i[i] && (prio[i] > max_prio)) max_prio = prio[i];
        end
        for (int i = 0; i < PORTS; i++) begin
            cand[i]  = request_i[i] && (prio[i] == max_prio);
            above[i] = (i > int'(last_q));
        end
    end

    axi_crossbar_qos_arbiter_priority_encoder #(.WIDTH(PORTS), .IDX_W(IDX_W)) u_enc_masked (
        .vec_i (cand & above),
        .vld_o (msk_vld),
        .idx_o (msk_idx)
    );

    axi_crossbar_qos_arbiter_priority_encoder #(.WIDTH(PORTS), .IDX_W(IDX_W)) u_enc_all (
        .vec_i (cand),
        .vld_o (all_vld),
        .idx_o (all_idx)
    );

    assign win_idx = msk_vld ? msk_idx : all_idx;

    always_comb begin
        held = 1'b0;
        if (grant_valid_q && (ARB_BLOCK != 0)) begin
            held = (ARB_BLOCK_ACK != 0) ? !acknowledge_i[grant_enc_q] : request_i[grant_enc_q];
        end
    end

    always_comb begin
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_enc_d   = grant_enc_q;
        grant_qos_d   = grant_qos_q;
        last_d        = last_q;
        if (!held) begin
            grant_d       = '0;
            grant_valid_d = all_vld;
            grant_enc_d   = '0;
            grant_qos_d   = '0;
            if (all_vld) begin
                grant_d[win_idx] = 1'b1;
                grant_enc_d      = win_idx;
                grant_qos_d      = req_qos_i[int'(win_idx)*QOS_WIDTH +: QOS_WIDTH];
                last_d           = win_idx;
            end
        end
    end

    // A port that holds or just received the grant is not waiting.
    always_comb begin
        age_d  = age_q;
        aged_d = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (!request_i[i] || grant_d[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != LIMIT_V) begin
                age_d[i] = age_q[i] + AGE_WIDTH'(1);
            end
            aged_d[i] = (AGE_LIMIT != 0) && (age_d[i] == LIMIT_V);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_enc_q   <= '0;
            grant_qos_q   <= '0;
            last_q        <= IDX_W'(PORTS - 1);
            age_q         <= '0;
            aged_q        <= '0;
        end else begin
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_enc_q   <= grant_enc_d;
            grant_qos_q   <= grant_qos_d;
            last_q        <= last_d;
            age_q         <= age_d;
            aged_q        <= aged_d;
        end
    end

    assign grant_o         = grant_q;
    assign grant_valid_o   = grant_valid_q;
    assign grant_encoded_o = grant_enc_q;
    assign grant_qos_o     = grant_qos_q;
    assign aged_o          = aged_q;

endmodule

// File: tb/tb_axi_crossbar_qos_arbiter.sv
// Bench for the QoS arbiter: an ack-hold and a request-hold instance share stimulus;
// a queue-based scoreboard compares each against a cycle model built from the arbitration rules.
module tb_axi_crossbar_qos_arbiter;

    localparam int NP  = 4;
    localparam int QW  = 4;
    localparam int LIM = 8;

    typedef struct packed {
        logic [3:0] grant;
        logic       vld;
        logic [1:0] enc;
        logic [3:0] qos;
        logic [3:0] aged;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  request = '0;
    logic [3:0]  acknowledge = '0;
    logic [15:0] req_qos = '0;

    logic [3:0] grant_a, aged_a, qos_a, grant_r, aged_r, qos_r;
    logic [1:0] enc_a, enc_r;
    logic       vld_a, vld_r;

    int n_chk = 0;
    int n_fail = 0;

    // Model state, index 0 = ack-hold instance, 1 = request-hold instance.
    int gidx[2];
    int last[2];
    int gq[2];
    int age[2][NP];

    obs_t q_a[$];
    obs_t q_r[$];

    always #5 clk = ~clk;

    axi_crossbar_qos_arbiter #(
        .PORTS(NP), .QOS_WIDTH(QW), .AGE_WIDTH(8), .AGE_LIMIT(LIM),
        .ARB_BLOCK(1), .ARB_BLOCK_ACK(1)
    ) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .request_i(request), .acknowledge_i(acknowledge),
        .req_qos_i(req_qos), .grant_o(grant_a), .grant_valid_o(vld_a),
        .grant_encoded_o(enc_a), .grant_qos_o(qos_a), .aged_o(aged_a)
    );

    axi_crossbar_qos_arbiter #(
        .PORTS(NP), .QOS_WIDTH(QW), .AGE_WIDTH(8), .AGE_LIMIT(LIM),
        .ARB_BLOCK(1), .ARB_BLOCK_ACK(0)
    ) dut_r (
        .clk_i(clk), .rst_n_i(rst_n), .request_i(request), .acknowledge_i(acknowledge),
        .req_qos_i(req_qos), .grant_o(grant_r), .grant_valid_o(vld_r),
        .grant_encoded_o(enc_r), .grant_qos_o(qos_r), .aged_o(aged_r)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t dut_obs(input int m);
        obs_t o;
        if (m == 0) o = '{grant_a, vld_a, enc_a, qos_a, aged_a};
        else        o = '{grant_r, vld_r, enc_r, qos_r, aged_r};
        return o;
    endfunction

    function automatic int qos_of(input int i);
        logic [15:0] q;
        q = req_qos;
        return int'(q[i*QW +: QW]);
    endfunction

    function automatic obs_t exp_obs(input int m);
        obs_t o;
        o.grant = (gidx[m] >= 0) ? 4'(1 << gidx[m]) : 4'd0;
        o.vld   = (gidx[m] >= 0);
        o.enc   = (gidx[m] >= 0) ? 2'(gidx[m]) : 2'd0;
        o.qos   = 4'(gq[m]);
        for (int i = 0; i < NP; i++) o.aged[i] = (age[m][i] == LIM);
        return o;
    endfunction

    function automatic logic [3:0] cur_ack();
        return (gidx[0] >= 0) ? 4'(1 << gidx[0]) : 4'd0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            gidx[m] = -1;
            last[m] = NP - 1;
            gq[m]   = 0;
            for (int i = 0; i < NP; i++) age[m][i] = 0;
        end
    endtask

    // One clock edge of the arbitration rules: hold check, rotating scan for the
    // strictly best priority starting after the last winner, then per-port aging.
    task automatic model_step(input int m);
        bit held;
        int best, bestp, p, i, nidx;
        held = 1'b0;
        if (gidx[m] >= 0) held = (m == 0) ? (acknowledge[gidx[m]] == 1'b0) : (request[gidx[m]] == 1'b1);
        nidx = gidx[m];
        if (!held) begin
            best = -1;
            bestp = -1;
            for (int k = 1; k <= NP; k++) begin
                i = (last[m] + k) % NP;
                p = (age[m][i] == LIM) ? (1 << QW) : qos_of(i);
                if (request[i] && p > bestp) begin
                    best = i;
                    bestp = p;
                end
            end
            nidx = best;
            gq[m] = (best >= 0) ? qos_of(best) : 0;
            if (best >= 0) last[m] = best;
        end
        gidx[m] = nidx;
        for (int j = 0; j < NP; j++) begin
            if (!request[j] || j == nidx) age[m][j] = 0;
            else age[m][j] = (age[m][j] + 1 > LIM) ? LIM : age[m][j] + 1;
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] a, input logic [15:0] q);
        @(negedge clk);
        request = r;
        acknowledge = a;
        req_qos = q;
        model_step(0);
        model_step(1);
        q_a.push_back(exp_obs(0));
        q_r.push_back(exp_obs(1));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        request = '0;
        acknowledge = '0;
        req_qos = '0;
        model_reset();
        #1;
        chk("reset_outputs_a", 32'(dut_obs(0)), 32'd0);
        chk("reset_outputs_r", 32'(dut_obs(1)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: one expected entry per clock edge for each instance.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("scoreboard_ackhold", 32'(dut_obs(0)), 32'(e));
            end
            if (q_r.size() > 0) begin
                e = q_r.pop_front();
                chk("scoreboard_reqhold", 32'(dut_obs(1)), 32'(e));
            end
        end
    end

    initial begin
        int rr_seq[5];
        int qos_seq[4];
        logic [3:0] r, a;
        rr_seq  = '{0, 1, 2, 3, 0};
        qos_seq = '{1, 2, 1, 2};
        model_reset();
        #2;
        chk("initial_reset_a", 32'(dut_obs(0)), 32'd0);
        do_reset();

        for (int k = 0; k < 5; k++) begin
            drive(4'hF, cur_ack(), 16'h0000);
            settle();
            chk("rr_sequence", 32'(enc_a), 32'(rr_seq[k]));
        end

        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(4'hF, cur_ack(), 16'h2551);
            settle();
            chk("qos_sequence", 32'(enc_a), 32'(qos_seq[k]));
            chk("qos_grant_qos", 32'(qos_a), 32'd5);
        end

        do_reset();
        for (int k = 1; k <= 9; k++) begin
            drive(4'b0011, cur_ack(), 16'h00F0);
            settle();
            if (k == 7) chk("aged0_not_yet", 32'(aged_a[0]), 32'd0);
            if (k == 8) begin
                chk("aged0_set_a", 32'(aged_a[0]), 32'd1);
                chk("aged0_set_r", 32'(aged_r[0]), 32'd1);
            end
            if (k == 9) begin
                chk("aged_port_wins", 32'(enc_a), 32'd0);
                chk("aged0_cleared", 32'(aged_a[0]), 32'd0);
            end
        end

        do_reset();
        drive(4'b0100, 4'b0000, 16'h0000);
        settle();
        chk("ackhold_grant", 32'(grant_a), 32'h4);
        for (int k = 0; k < 5; k++) begin
            drive(4'b0000, 4'b0000, 16'h0000);
            settle();
            chk("ackhold_keep", 32'(grant_a), 32'h4);
        end
        drive(4'b0010, 4'b1000, 16'h0000);
        settle();
        chk("ack_other_ignored", 32'(grant_a), 32'h4);
        drive(4'b0010, 4'b0100, 16'h0000);
        settle();
        chk("ack_release_regrant", 32'(grant_a), 32'h2);

        do_reset();
        drive(4'b0010, 4'b0000, 16'h0000);
        settle();
        chk("reqhold_grant", 32'(grant_r), 32'h2);
        for (int k = 0; k < 3; k++) begin
            drive(4'b1010, 4'b0000, 16'h0000);
            settle();
            chk("reqhold_keep", 32'(grant_r), 32'h2);
        end
        drive(4'b1000, 4'b0000, 16'h0000);
        settle();
        chk("reqhold_drop_regrant", 32'(grant_r), 32'h8);

        do_reset();
        for (int k = 0; k < 10; k++) drive(4'b0011, 4'b0000, 16'h0090);
        settle();
        chk("midgrant_grant", 32'(grant_a), 32'h2);
        chk("midgrant_aged", 32'(aged_a), 32'h1);
        do_reset();
        drive(4'hF, 4'b0000, 16'h0000);
        settle();
        chk("post_reset_tie", 32'(enc_a), 32'd0);

        do_reset();
        for (int k = 0; k < 1500; k++) begin
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom & $urandom) : 4'($urandom);
            a = 4'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 1) == 1) a = a | cur_ack();
            drive(r, a, 16'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("queue_a_drained", 32'(q_a.size()), 32'd0);
        chk("queue_r_drained", 32'(q_r.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
